fetch_sequencer: RTL and testbench

Program sequencer for the simple processor. It replaces the free-running address counter with a handshaken fetch–issue–wait loop on the single processor clock. It fetches one instruction word from the synchronous instruction memory, presents it on the processor data input, and pulses `run`. It then waits for the control unit's `done` before advancing. It also provides halt detection, single-step mode, wrap-around and a `done` watchdog.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_watchdog.sv | 28 ++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the fetch/issue/wait program sequencer.
// No logic here: state encoding, instruction-count width, default halt opcode.
package seq_pkg;

  localparam int          INSTR_CNT_W       = 8;
  localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_NEXT  = 3'd5,
    S_PAUSE = 3'd6,
    S_HALT  = 3'd7
  } seq_state_t;

  // Parked states wait for start; every other state is mid-instruction.
  function automatic logic is_busy_state(input seq_state_t s);
    return !(s inside {S_IDLE, S_PAUSE, S_HALT});
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Counts EXEC cycles since the last issue; expired flags the TIMEOUT-th one.
// expired is combinational from the count and enable; clear has priority over counting.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds completed EXEC cycles, so the current cycle is number cnt+1.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: fetch a word, latch it onto din, pulse run, wait for cu_done.
// run follows start by 3 cycles; the next fetch waits on cu_done (watchdog-bounded).
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 16,
  parameter int                PROG_LEN  = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEFAULT_HALT_WORD),
  parameter int                TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   step_mode,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_q,
  output logic [DATA_W-1:0]      din,
  output logic                   run,
  input  logic                   cu_done,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              wd_expired;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == S_ISSUE),
    .enable  (state == S_EXEC),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_PAUSE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = (mem_q == HALT_WORD) ? S_HALT : S_ISSUE;
      S_ISSUE: state_nxt = S_EXEC;
      // A done arriving on the last allowed cycle beats the watchdog.
      S_EXEC: begin
        if (cu_done)         state_nxt = S_NEXT;
        else if (wd_expired) state_nxt = S_HALT;
      end
      S_NEXT:  state_nxt = step_mode ? S_PAUSE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      din         <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
      run         <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Status flags are decoded from the next state so they are true flops.
      run    <= (state_nxt == S_ISSUE);
      busy   <= is_busy_state(state_nxt);
      halted <= (state_nxt == S_HALT);
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
          end
        end
        S_LATCH: begin
          if (mem_q != HALT_WORD) din <= mem_q;
        end
        S_EXEC: begin
          if (!cu_done && wd_expired) fault <= 1'b1;
        end
        S_NEXT: begin
          if (instr_count != '1) instr_count <= instr_count + 1'b1;
          pc <= (pc == LAST_ADDR) ? '0 : pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table, directed corner sequences, and a
// randomized run checked against a time-arithmetic model of the sequencing rules.
module tb_fetch_sequencer;
  import seq_pkg::*;

  localparam int          ADDR_W   = 5;
  localparam int          DATA_W   = 16;
  localparam int          PROG_LEN = 4;
  localparam int          TIMEOUT  = 20;
  localparam logic [15:0] HW       = 16'hFFFF;

  logic              clk = 1'b0;
  logic              reset_n, start, step_mode, cu_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q = '0;
  logic [DATA_W-1:0] din;
  logic              run, busy, halted, fault;
  logic [7:0]        instr_count;

  logic [DATA_W-1:0] prog [32];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_run = 0;
  int   n0, nr;
  logic s_run = 1'b0;
  logic sm_r = 1'b0;
  logic [4:0] addrs [6];

  fetch_sequencer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PROG_LEN  (PROG_LEN),
    .HALT_WORD (HW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .step_mode   (step_mode),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .din         (din),
    .run         (run),
    .cu_done     (cu_done),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM.
  always @(posedge clk) mem_q <= prog[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [32:0] outs();
    return {run, busy, halted, fault, mem_addr, din, instr_count};
  endfunction

  // Reference model: tracks the cycle number at which the current fetch began
  // and the cycle at which the current instruction retires.
  bit          m_valid = 0, model_chk = 0;
  bit          m_idle, m_paused, m_halted, m_fault;
  int          m_fetch_t, m_next_t, m_pc, m_cnt;
  logic [15:0] m_din;

  function automatic logic [32:0] model_outs();
    bit running;
    running = !(m_idle || m_paused || m_halted);
    return {logic'(running && (cyc == m_fetch_t + 2)), logic'(running), logic'(m_halted),
            logic'(m_fault), 5'(m_pc), m_din, 8'(m_cnt)};
  endfunction

  task automatic model_step(input logic rn, input logic st, input logic sm, input logic cd);
    if (!rn) begin
      m_valid = 1; m_idle = 1; m_paused = 0; m_halted = 0; m_fault = 0;
      m_pc = 0; m_cnt = 0; m_din = '0; m_fetch_t = -10; m_next_t = -1;
    end else if (m_idle || m_paused || m_halted) begin
      if (st) begin
        if (!m_paused) begin m_pc = 0; m_cnt = 0; m_fault = 0; end
        m_idle = 0; m_paused = 0; m_halted = 0;
        m_fetch_t = cyc + 1; m_next_t = -1;
      end
    end else if (m_next_t == cyc) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_pc = (m_pc + 1) % PROG_LEN;
      m_next_t = -1;
      if (sm) m_paused = 1;
      else    m_fetch_t = cyc + 1;
    end else if (cyc == m_fetch_t + 1) begin
      if (prog[m_pc] == HW) m_halted = 1;
      else                  m_din = prog[m_pc];
    end else if (cyc > m_fetch_t + 2) begin
      if (cd) m_next_t = cyc + 1;
      else if (cyc - (m_fetch_t + 2) >= TIMEOUT) begin m_fault = 1; m_halted = 1; end
    end
  endtask

  // One clock cycle: sample outputs of this cycle, then drive this cycle's inputs.
  task automatic tick(input logic rn, input logic st, input logic sm, input logic cd);
    @(negedge clk);
    s_run = run;
    if (run === 1'b1) n_run++;
    if (model_chk && m_valid) check("model", 64'(outs()), 64'(model_outs()));
    reset_n = rn; start = st; step_mode = sm; cu_done = cd;
    model_step(rn, st, sm, cd);
    cyc++;
  endtask

  typedef struct {
    logic        rn, st, cd;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t v(input logic rn, input logic st, input logic cd,
                             input logic r, input logic b, input logic h, input logic f,
                             input logic [4:0] a, input logic [15:0] d, input logic [7:0] c);
    vec_t x;
    x.rn = rn; x.st = st; x.cd = cd; x.exp = {r, b, h, f, a, d, c};
    return x;
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; step_mode = 1'b0; cu_done = 1'b0;
    for (int a = 0; a < 32; a++) prog[a] = 16'h0;

    // ---- Table: program {1,2,HALT}, done 2 cycles after run, restart, reset mid-EXEC
    prog[0] = 16'h0001; prog[1] = 16'h0002; prog[2] = HW; prog[3] = 16'h0007;
    //            rn st cd  run busy hlt flt addr din  cnt
    tbl[0]  = v(1, 1, 0,  0, 0, 0, 0, 0, 16'h0, 0);
    tbl[1]  = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h0, 0);
    tbl[2]  = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h0, 0);
    tbl[3]  = v(1, 0, 0,  1, 1, 0, 0, 0, 16'h1, 0);
    tbl[4]  = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[5]  = v(1, 0, 1,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[6]  = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[7]  = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h1, 1);
    tbl[8]  = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h1, 1);
    tbl[9]  = v(1, 0, 0,  1, 1, 0, 0, 1, 16'h2, 1);
    tbl[10] = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h2, 1);
    tbl[11] = v(1, 0, 1,  0, 1, 0, 0, 1, 16'h2, 1);
    tbl[12] = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h2, 1);
    tbl[13] = v(1, 0, 0,  0, 1, 0, 0, 2, 16'h2, 2);
    tbl[14] = v(1, 0, 0,  0, 1, 0, 0, 2, 16'h2, 2);
    tbl[15] = v(1, 0, 0,  0, 0, 1, 0, 2, 16'h2, 2);
    tbl[16] = v(1, 1, 0,  0, 0, 1, 0, 2, 16'h2, 2);
    tbl[17] = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h2, 0);
    tbl[18] = v(1, 0, 0,  0, 1, 0, 0, 0, 16'h2, 0);
    tbl[19] = v(1, 0, 0,  1, 1, 0, 0, 0, 16'h1, 0);
    tbl[20] = v(1, 1, 0,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[21] = v(1, 1, 0,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[22] = v(1, 0, 1,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[23] = v(1, 1, 0,  0, 1, 0, 0, 0, 16'h1, 0);
    tbl[24] = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h1, 1);
    tbl[25] = v(1, 0, 0,  0, 1, 0, 0, 1, 16'h1, 1);
    tbl[26] = v(1, 0, 0,  1, 1, 0, 0, 1, 16'h2, 1);
    tbl[27] = v(0, 0, 0,  0, 1, 0, 0, 1, 16'h2, 1);
    tbl[28] = v(1, 0, 0,  0, 0, 0, 0, 0, 16'h0, 0);
    tbl[29] = v(1, 0, 1,  0, 0, 0, 0, 0, 16'h0, 0);
    tbl[30] = v(1, 0, 0,  0, 0, 0, 0, 0, 16'h0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 31; i++) begin
      tick(tbl[i].rn, tbl[i].st, 1'b0, tbl[i].cd);
      check($sformatf("table_row%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end

    // ---- Step mode: one run per start pulse, parked (not busy) in between
    prog[0] = 16'h0011; prog[1] = 16'h0022; prog[2] = 16'h0033; prog[3] = 16'h0044;
    tick(0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      n0 = n_run;
      tick(1, 1, 1, 0);
      repeat (3) tick(1, 0, 1, 0);
      check("step_run", 64'(run), 64'(1));
      check("step_din", 64'(din), 64'(prog[k-1]));
      tick(1, 0, 1, 0); tick(1, 0, 1, 1); tick(1, 0, 1, 0); tick(1, 0, 1, 0);
      check("step_pause", 64'({busy, halted, instr_count, mem_addr}),
            64'({1'b0, 1'b0, 8'(k), 5'(k)}));
      repeat (4) tick(1, 0, 1, 0);
      check("step_one_run", 64'(n_run - n0), 64'(1));
    end
    tick(1, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0);
    check("step_last_din", 64'({din, mem_addr}), 64'({16'h0044, 5'd3}));
    tick(1, 0, 0, 0); tick(1, 0, 0, 1); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    check("step_off_wrap", 64'({busy, mem_addr, instr_count}), 64'({1'b1, 5'd0, 8'd4}));

    // ---- Wrap-around address order and instr_count saturation over 300 instructions
    prog[0] = 16'h0005; prog[1] = 16'h0006; prog[2] = 16'h0007; prog[3] = 16'h0008;
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    nr = 0;
    for (int i = 0; i < 2000 && nr < 300; i++) begin
      tick(1, 0, 0, s_run);
      if (s_run === 1'b1) begin
        nr++;
        if (nr <= 6) addrs[nr-1] = mem_addr;
        if (nr == 255) check("cnt_at_255", 64'(instr_count), 64'(254));
        if (nr == 257) check("cnt_at_257", 64'(instr_count), 64'(255));
      end
    end
    check("wrap_runs", 64'(nr), 64'(300));
    tick(1, 0, 0, 1); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    check("cnt_saturated", 64'(instr_count), 64'(255));
    for (int k = 0; k < 6; k++) check($sformatf("wrap_addr%0d", k), 64'(addrs[k]), 64'(k % 4));

    // ---- Watchdog: done on the last allowed cycle wins, silence faults, start clears
    prog[0] = 16'h0009; prog[1] = 16'h000A; prog[2] = 16'h000B; prog[3] = 16'h000C;
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0);
    check("wd_issue0", 64'({run, din}), 64'({1'b1, 16'h0009}));
    repeat (TIMEOUT - 1) tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 0);
    check("wd_late_done", 64'({fault, halted, busy}), 64'({1'b0, 1'b0, 1'b1}));
    tick(1, 0, 0, 0);
    check("wd_late_retired", 64'({instr_count, mem_addr}), 64'({8'd1, 5'd1}));
    repeat (2) tick(1, 0, 0, 0);
    check("wd_issue1", 64'({run, din}), 64'({1'b1, 16'h000A}));
    repeat (TIMEOUT) tick(1, 0, 0, 0);
    check("wd_last_exec", 64'({fault, halted, busy}), 64'({1'b0, 1'b0, 1'b1}));
    tick(1, 0, 0, 0);
    check("wd_fault", 64'({fault, halted, busy, instr_count, mem_addr}),
          64'({1'b1, 1'b1, 1'b0, 8'd1, 5'd1}));
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    check("halt_restart", 64'({fault, halted, busy, instr_count, mem_addr}),
          64'({1'b0, 1'b0, 1'b1, 8'd0, 5'd0}));
    repeat (2) tick(1, 0, 0, 0);
    check("halt_refetch", 64'({run, din}), 64'({1'b1, 16'h0009}));

    // ---- Randomized traffic against the reference model
    model_chk = 1;
    for (int ep = 0; ep < 6; ep++) begin
      for (int a = 0; a < 32; a++)
        prog[a] = ($urandom_range(0, 5) == 0) ? HW : 16'($urandom_range(0, 16'hFFFE));
      tick(0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) sm_r = ~sm_r;
        tick(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 3) == 0),
             sm_r, logic'($urandom_range(0, 7) == 0));
      end
    end
    model_chk = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
